// File: rtl/icache_miss_ctrl_pkg.sv
// Shared frontend definitions for the icache miss path: L2 op codes, miss FSM
// states, line-offset widths and the serviced-slot mask.
package icache_miss_ctrl_pkg;

  typedef enum logic [2:0] {
    L2_NOP    = 3'd0,
    L2_READ   = 3'd1,
    L2_W      = 3'd2,
    L2_RWITM  = 3'd3,
    L2_FLUSH  = 3'd4,
    L2_UPDATE = 3'd5
  } l2_op_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    FILL
  } state_e;

  localparam int unsigned L2_OFF_BITS = 6;
  localparam int unsigned CL_OFF_BITS = 4;

  typedef struct packed {
    logic pf;
    logic odd;
    logic even;
  } slot_mask_t;

endpackage

// File: rtl/icache_miss_slot.sv
// One pending-miss slot: valid bit plus address, with set/clear/flush and an
// L2-line compare against an external line address.
module icache_miss_slot
  import icache_miss_ctrl_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        set,
  input  logic [XLEN-1:0]             set_addr,
  input  logic                        clr,
  input  logic                        flush,
  input  logic [XLEN-L2_OFF_BITS-1:0] cmp_line,
  output logic                        valid,
  output logic [XLEN-1:0]             addr,
  output logic                        match
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] addr_q, addr_d;

  // A slot being cleared this cycle may accept a new request in the same cycle.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (set && (clr || !valid_q)) begin
      valid_d = 1'b1;
      addr_d  = set_addr;
    end else if (clr) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign valid = valid_q;
  assign addr  = addr_q;
  assign match = valid_q && (addr_q[XLEN-1:L2_OFF_BITS] == cmp_line);

endmodule

// File: rtl/icache_miss_ctrl.sv
// Icache miss sequencer: arbitrates even/odd demand misses and prefetches into
// a single outstanding L2 read, then writes the returned sub-lines to the icache.
module icache_miss_ctrl
  import icache_miss_ctrl_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned CL_SIZE    = 128,
  parameter int unsigned L2_CL_SIZE = 512
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_even_valid,
  input  logic [XLEN-1:0]       miss_even_addr,
  input  logic                  miss_odd_valid,
  input  logic [XLEN-1:0]       miss_odd_addr,
  input  logic                  prefetch_valid,
  input  logic [XLEN-1:0]       prefetch_addr,
  input  logic                  resteer,
  input  logic                  l2_req_ready,
  output logic [2:0]            icache_l2_op,
  output logic [XLEN-1:0]       icache_l2_addr,
  input  logic [2:0]            l2_icache_op,
  input  logic [XLEN-1:0]       l2_icache_addr,
  input  logic [L2_CL_SIZE-1:0] l2_icache_data,
  input  logic [2:0]            l2_icache_state,
  output logic                  fill_valid,
  output logic [XLEN-1:0]       fill_addr,
  output logic [CL_SIZE-1:0]    fill_data,
  output logic [2:0]            fill_state,
  output logic                  stall_out,
  output logic                  busy
);

  localparam int unsigned LINE_W = XLEN - L2_OFF_BITS;

  state_e                state_q, state_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [XLEN-1:0]       fa0_q, fa0_d, fa1_q, fa1_d;
  logic                  two_q, two_d;
  logic                  fidx_q, fidx_d;
  logic                  demand_q, demand_d;
  logic [L2_CL_SIZE-1:0] data_q, data_d;
  logic [2:0]            lstate_q, lstate_d;

  slot_mask_t            clr_mask;
  logic                  even_v, odd_v, pf_v;
  logic [XLEN-1:0]       even_a, odd_a, pf_a;
  logic                  even_m, odd_m, pf_m;
  logic [LINE_W-1:0]     pf_line;
  logic                  pf_drop;
  logic                  merge;
  logic [XLEN-1:0]       cur_addr;
  logic                  unused_ok;

  assign pf_line = prefetch_addr[XLEN-1:L2_OFF_BITS];
  // pf_m also catches a prefetch slot being launched this cycle: that line is
  // about to be in flight, so a repeat prefetch of it is redundant.
  assign pf_drop = even_m | odd_m | pf_m | ((state_q != IDLE) && (line_q == pf_line));
  assign merge   = odd_v && (even_a[XLEN-1:L2_OFF_BITS] == odd_a[XLEN-1:L2_OFF_BITS]);

  icache_miss_slot #(.XLEN(XLEN)) u_slot_even (
    .clk      (clk),
    .rst      (rst),
    .set      (miss_even_valid & ~resteer),
    .set_addr (miss_even_addr),
    .clr      (clr_mask.even),
    .flush    (resteer),
    .cmp_line (pf_line),
    .valid    (even_v),
    .addr     (even_a),
    .match    (even_m)
  );

  icache_miss_slot #(.XLEN(XLEN)) u_slot_odd (
    .clk      (clk),
    .rst      (rst),
    .set      (miss_odd_valid & ~resteer),
    .set_addr (miss_odd_addr),
    .clr      (clr_mask.odd),
    .flush    (resteer),
    .cmp_line (pf_line),
    .valid    (odd_v),
    .addr     (odd_a),
    .match    (odd_m)
  );

  icache_miss_slot #(.XLEN(XLEN)) u_slot_pf (
    .clk      (clk),
    .rst      (rst),
    .set      (prefetch_valid & ~resteer & ~pf_drop),
    .set_addr (prefetch_addr),
    .clr      (clr_mask.pf),
    .flush    (resteer),
    .cmp_line (pf_line),
    .valid    (pf_v),
    .addr     (pf_a),
    .match    (pf_m)
  );

  always_comb begin
    state_d  = state_q;
    line_d   = line_q;
    fa0_d    = fa0_q;
    fa1_d    = fa1_q;
    two_d    = two_q;
    fidx_d   = fidx_q;
    demand_d = demand_q;
    data_d   = data_q;
    lstate_d = lstate_q;
    clr_mask = '0;
    case (state_q)
      IDLE: begin
        if (!resteer && (even_v || odd_v || pf_v)) begin
          state_d = REQ;
          fidx_d  = 1'b0;
          if (even_v) begin
            line_d        = even_a[XLEN-1:L2_OFF_BITS];
            fa0_d         = even_a;
            fa1_d         = odd_a;
            two_d         = merge;
            clr_mask.even = 1'b1;
            clr_mask.odd  = merge;
          end else if (odd_v) begin
            line_d       = odd_a[XLEN-1:L2_OFF_BITS];
            fa0_d        = odd_a;
            two_d        = 1'b0;
            clr_mask.odd = 1'b1;
          end else begin
            line_d      = pf_a[XLEN-1:L2_OFF_BITS];
            fa0_d       = pf_a;
            two_d       = 1'b0;
            clr_mask.pf = 1'b1;
          end
          demand_d = clr_mask.even | clr_mask.odd;
        end
      end
      REQ: begin
        if (l2_req_ready) begin
          state_d = WAIT;
        end else if (resteer) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if ((l2_icache_op == L2_READ) && (l2_icache_addr[XLEN-1:L2_OFF_BITS] == line_q)) begin
          state_d  = FILL;
          data_d   = l2_icache_data;
          lstate_d = l2_icache_state;
        end
      end
      FILL: begin
        if (!two_q || fidx_q) begin
          state_d  = IDLE;
          demand_d = 1'b0;
        end else begin
          fidx_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    // An accepted read still completes after a flush; only the stall is released.
    if (resteer) begin
      demand_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      line_q   <= '0;
      fa0_q    <= '0;
      fa1_q    <= '0;
      two_q    <= 1'b0;
      fidx_q   <= 1'b0;
      demand_q <= 1'b0;
      data_q   <= '0;
      lstate_q <= '0;
    end else begin
      state_q  <= state_d;
      line_q   <= line_d;
      fa0_q    <= fa0_d;
      fa1_q    <= fa1_d;
      two_q    <= two_d;
      fidx_q   <= fidx_d;
      demand_q <= demand_d;
      data_q   <= data_d;
      lstate_q <= lstate_d;
    end
  end

  assign cur_addr       = fidx_q ? fa1_q : fa0_q;
  assign icache_l2_op   = (state_q == REQ) ? L2_READ : L2_NOP;
  assign icache_l2_addr = (state_q == REQ) ? {line_q, {L2_OFF_BITS{1'b0}}} : '0;
  assign fill_valid     = (state_q == FILL);
  assign fill_addr      = fill_valid ? {cur_addr[XLEN-1:CL_OFF_BITS], {CL_OFF_BITS{1'b0}}} : '0;
  assign fill_data      = fill_valid ? data_q[CL_SIZE*cur_addr[L2_OFF_BITS-1:CL_OFF_BITS] +: CL_SIZE] : '0;
  assign fill_state     = fill_valid ? lstate_q : '0;
  assign stall_out      = even_v | odd_v | demand_q;
  assign busy           = (state_q != IDLE);

  assign unused_ok = ^{cur_addr[CL_OFF_BITS-1:0], l2_icache_addr[L2_OFF_BITS-1:0]};

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Self-checking bench for icache_miss_ctrl: directed scenarios plus randomized
// miss/prefetch mixes checked against a transaction-level model of reads and fills.
module tb_icache_miss_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         miss_even_valid, miss_odd_valid, prefetch_valid, resteer, l2_req_ready;
  logic [31:0]  miss_even_addr, miss_odd_addr, prefetch_addr;
  logic [2:0]   icache_l2_op, l2_icache_op, l2_icache_state, fill_state;
  logic [31:0]  icache_l2_addr, l2_icache_addr, fill_addr;
  logic [511:0] l2_icache_data;
  logic [127:0] fill_data;
  logic         fill_valid, stall_out, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  int ready_pct = 100;
  int spur_pct = 0;
  int resp_dly = 0;
  int resp_cnt = 0;
  logic [25:0] resp_line;
  bit last_fill = 0;
  bit stall_any = 0;

  logic [31:0]  rd_obs[$];
  logic [31:0]  fa_obs[$];
  logic [127:0] fd_obs[$];
  logic [2:0]   fs_obs[$];
  bit           fst_obs[$];
  bit           fsa_obs[$];
  int           fc_obs[$];
  logic [511:0] rdata[$];
  logic [2:0]   rstate[$];
  int           rcyc[$];

  typedef struct {
    logic [31:0] a;
    int          rd;
    int          j;
    bit          dem;
  } fexp_t;

  icache_miss_ctrl #(.XLEN(32), .CL_SIZE(128), .L2_CL_SIZE(512)) dut (
    .clk             (clk),
    .rst             (rst),
    .miss_even_valid (miss_even_valid),
    .miss_even_addr  (miss_even_addr),
    .miss_odd_valid  (miss_odd_valid),
    .miss_odd_addr   (miss_odd_addr),
    .prefetch_valid  (prefetch_valid),
    .prefetch_addr   (prefetch_addr),
    .resteer         (resteer),
    .l2_req_ready    (l2_req_ready),
    .icache_l2_op    (icache_l2_op),
    .icache_l2_addr  (icache_l2_addr),
    .l2_icache_op    (l2_icache_op),
    .l2_icache_addr  (l2_icache_addr),
    .l2_icache_data  (l2_icache_data),
    .l2_icache_state (l2_icache_state),
    .fill_valid      (fill_valid),
    .fill_addr       (fill_addr),
    .fill_data       (fill_data),
    .fill_state      (fill_state),
    .stall_out       (stall_out),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rand_line();
    logic [511:0] v;
    for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // One clock of observation plus L2 behaviour; inputs set on return apply at the next edge.
  task automatic cycle();
    logic [511:0] d;
    logic [2:0]   st;
    @(negedge clk);
    cyc++;
    if (last_fill) fsa_obs.push_back(stall_out);
    last_fill = fill_valid;
    if (stall_out) stall_any = 1;
    if (fill_valid) begin
      fa_obs.push_back(fill_addr);
      fd_obs.push_back(fill_data);
      fs_obs.push_back(fill_state);
      fst_obs.push_back(stall_out);
      fc_obs.push_back(cyc);
    end
    l2_icache_op    = 3'd0;
    l2_icache_addr  = '0;
    l2_icache_data  = '0;
    l2_icache_state = '0;
    l2_req_ready    = 1'b0;
    if (resp_cnt > 0) begin
      resp_cnt--;
      if (resp_cnt == 0) begin
        d  = rand_line();
        st = 3'($urandom);
        l2_icache_op    = 3'd1;
        l2_icache_addr  = {resp_line, 6'($urandom)};
        l2_icache_data  = d;
        l2_icache_state = st;
        rdata.push_back(d);
        rstate.push_back(st);
        rcyc.push_back(cyc);
      end else if ($urandom_range(0, 99) < spur_pct) begin
        l2_icache_data  = rand_line();
        l2_icache_state = 3'($urandom);
        if ($urandom_range(0, 1) == 0) begin
          l2_icache_op   = 3'd1;
          l2_icache_addr = {resp_line + 26'h40, 6'h0};
        end else begin
          l2_icache_op   = 3'($urandom_range(2, 7));
          l2_icache_addr = {resp_line, 6'h0};
        end
      end
    end
    if (icache_l2_op == 3'd1 && $urandom_range(0, 99) < ready_pct) begin
      l2_req_ready = 1'b1;
      rd_obs.push_back(icache_l2_addr);
      resp_line = icache_l2_addr[31:6];
      resp_cnt  = (resp_dly != 0) ? resp_dly : $urandom_range(1, 4);
    end
  endtask

  task automatic drain();
    int idle = 0;
    int n = 0;
    while (idle < 3 && n < 300) begin
      cycle();
      n++;
      if (!busy && !stall_out && resp_cnt == 0) idle++;
      else idle = 0;
    end
    check_eq("drain_bound", 512'(n < 300), 512'(1));
  endtask

  task automatic clear_obs();
    rd_obs.delete(); fa_obs.delete(); fd_obs.delete(); fs_obs.delete();
    fst_obs.delete(); fsa_obs.delete(); fc_obs.delete();
    rdata.delete(); rstate.delete(); rcyc.delete();
    stall_any = 0;
  endtask

  // pfw: 0 no prefetch, 1 prefetch alongside the demands, 2 prefetch one cycle later.
  task automatic run_scn(input string nm, input bit ev, input logic [31:0] ea, input bit od,
                         input logic [31:0] oa, input int pfw, input logic [31:0] pa, input bit lat);
    logic [25:0]  er[$];
    fexp_t        ef[$];
    fexp_t        e;
    bit           same, drop, later;
    logic [511:0] line;
    clear_obs();
    same = ev && od && (ea[31:6] == oa[31:6]);
    if (ev) begin
      er.push_back(ea[31:6]);
      ef.push_back('{ea, er.size() - 1, 0, 1'b1});
      if (same) ef.push_back('{oa, er.size() - 1, 1, 1'b1});
    end
    if (od && !same) begin
      er.push_back(oa[31:6]);
      ef.push_back('{oa, er.size() - 1, 0, 1'b1});
    end
    drop = (pfw == 2) && ((ev && pa[31:6] == ea[31:6]) || (od && pa[31:6] == oa[31:6]));
    if (pfw != 0 && !drop) begin
      er.push_back(pa[31:6]);
      ef.push_back('{pa, er.size() - 1, 0, 1'b0});
    end

    miss_even_valid = ev; miss_even_addr = ea;
    miss_odd_valid  = od; miss_odd_addr  = oa;
    prefetch_valid  = (pfw == 1); prefetch_addr = pa;
    cycle();
    miss_even_valid = 0; miss_odd_valid = 0;
    prefetch_valid  = (pfw == 2);
    if (lat) check_eq({nm, "_op_c1"}, 512'(icache_l2_op), 512'(0));
    cycle();
    prefetch_valid = 0;
    if (lat) begin
      check_eq({nm, "_op_c2"}, 512'(icache_l2_op), 512'(1));
      check_eq({nm, "_addr_c2"}, 512'(icache_l2_addr), 512'({er[0], 6'h0}));
    end
    drain();

    check_eq({nm, "_nreads"}, 512'(rd_obs.size()), 512'(er.size()));
    for (int i = 0; i < er.size() && i < rd_obs.size(); i++)
      check_eq($sformatf("%s_rd%0d", nm, i), 512'(rd_obs[i]), 512'({er[i], 6'h0}));
    check_eq({nm, "_nfills"}, 512'(fa_obs.size()), 512'(ef.size()));
    for (int i = 0; i < ef.size() && i < fa_obs.size(); i++) begin
      e = ef[i];
      check_eq($sformatf("%s_faddr%0d", nm, i), 512'(fa_obs[i]), 512'({e.a[31:4], 4'h0}));
      check_eq($sformatf("%s_stall_at%0d", nm, i), 512'(fst_obs[i]), 512'(e.dem));
      later = 0;
      for (int k = i + 1; k < ef.size(); k++) if (ef[k].dem) later = 1;
      if (i < fsa_obs.size())
        check_eq($sformatf("%s_stall_after%0d", nm, i), 512'(fsa_obs[i]), 512'(e.dem && later));
      if (e.rd < rdata.size()) begin
        line = rdata[e.rd];
        check_eq($sformatf("%s_fdata%0d", nm, i), 512'(fd_obs[i]), 512'(line[128*e.a[5:4] +: 128]));
        check_eq($sformatf("%s_fstate%0d", nm, i), 512'(fs_obs[i]), 512'(rstate[e.rd]));
        check_eq($sformatf("%s_fcyc%0d", nm, i), 512'(fc_obs[i]), 512'(rcyc[e.rd] + 1 + e.j));
      end
    end
    check_eq({nm, "_stall_any"}, 512'(stall_any), 512'(ev || od));
  endtask

  function automatic logic [31:0] rand_addr();
    return 32'h0001_0000 + ($urandom_range(0, 3) << 6) + $urandom_range(0, 63);
  endfunction

  initial begin
    logic [31:0] ea, oa, pa;
    rst = 1'b1;
    miss_even_valid = 0; miss_odd_valid = 0; prefetch_valid = 0; resteer = 0;
    miss_even_addr = '0; miss_odd_addr = '0; prefetch_addr = '0;
    l2_req_ready = 0; l2_icache_op = '0; l2_icache_addr = '0; l2_icache_data = '0; l2_icache_state = '0;
    repeat (2) @(negedge clk);
    check_eq("rst_op", 512'(icache_l2_op), 512'(0));
    check_eq("rst_l2addr", 512'(icache_l2_addr), 512'(0));
    check_eq("rst_fill", 512'({fill_valid, fill_addr, fill_state}), 512'(0));
    check_eq("rst_fdata", 512'(fill_data), 512'(0));
    check_eq("rst_stall_busy", 512'({stall_out, busy}), 512'(0));
    rst = 1'b0;
    cycle();

    resp_dly = 5;
    run_scn("t1", 1, 32'h0000_1040, 0, 0, 0, 0, 1);
    resp_dly = 0;
    run_scn("t2", 1, 32'h0000_2000, 1, 32'h0000_2010, 0, 0, 1);
    run_scn("t3", 1, 32'h0000_3000, 1, 32'h0000_4010, 0, 0, 1);
    spur_pct = 100; resp_dly = 3;
    run_scn("t4", 0, 0, 0, 0, 1, 32'h0000_5020, 0);
    spur_pct = 0; resp_dly = 0;
    run_scn("pfdrop", 1, 32'h0000_5830, 0, 0, 2, 32'h0000_5800, 0);

    // resteer while the request is still unaccepted
    clear_obs();
    ready_pct = 0;
    miss_even_valid = 1; miss_even_addr = 32'h0000_7000;
    cycle();
    miss_even_valid = 0;
    cycle();
    check_eq("rs_req_op", 512'(icache_l2_op), 512'(1));
    resteer = 1;
    cycle();
    resteer = 0;
    check_eq("rs_op_nop", 512'(icache_l2_op), 512'(0));
    check_eq("rs_idle", 512'({busy, stall_out}), 512'(0));
    ready_pct = 100;
    repeat (6) cycle();
    check_eq("rs_no_read", 512'(rd_obs.size()), 512'(0));
    check_eq("rs_no_fill", 512'(fa_obs.size()), 512'(0));

    // resteer after acceptance: read completes, stall released, coincident miss dropped
    clear_obs();
    resp_dly = 4;
    miss_even_valid = 1; miss_even_addr = 32'h0000_8050;
    cycle();
    miss_even_valid = 0;
    repeat (2) cycle();
    resteer = 1; miss_odd_valid = 1; miss_odd_addr = 32'h0000_9000;
    cycle();
    resteer = 0; miss_odd_valid = 0;
    check_eq("rsw_stall", 512'(stall_out), 512'(0));
    check_eq("rsw_busy", 512'(busy), 512'(1));
    drain();
    check_eq("rsw_nreads", 512'(rd_obs.size()), 512'(1));
    check_eq("rsw_nfills", 512'(fa_obs.size()), 512'(1));
    if (fa_obs.size() > 0) begin
      check_eq("rsw_faddr", 512'(fa_obs[0]), 512'(32'h0000_8050));
      check_eq("rsw_fstall", 512'(fst_obs[0]), 512'(0));
    end

    // reset during WAIT, response arrives afterwards
    clear_obs();
    resp_dly = 3;
    miss_even_valid = 1; miss_even_addr = 32'h0000_A000;
    cycle();
    miss_even_valid = 0;
    repeat (2) cycle();
    check_eq("rw_busy", 512'(busy), 512'(1));
    rst = 1'b1;
    #1;
    check_eq("rw_outs", 512'({icache_l2_op, icache_l2_addr, fill_valid, fill_addr, fill_state, stall_out, busy}), 512'(0));
    cycle();
    rst = 1'b0;
    drain();
    check_eq("rw_no_fill", 512'(fa_obs.size()), 512'(0));
    resp_dly = 0;

    for (int s = 0; s < 40; s++) begin
      ready_pct = $urandom_range(30, 100);
      spur_pct  = 40;
      ea = rand_addr();
      oa = ($urandom_range(0, 1) == 0) ? {ea[31:6], 6'($urandom)} : rand_addr();
      pa = ($urandom_range(0, 1) == 0) ? {ea[31:6], 6'($urandom)} : rand_addr();
      run_scn($sformatf("r%0d", s), 1'($urandom_range(0, 1)), ea, 1'($urandom_range(0, 1)), oa,
              $urandom_range(0, 2), pa, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/icache_miss_ctrl.md
Name: icache_miss_ctrl

Overview:
- Sequences instruction-cache misses to L2 and returns fills to the icache.
- Sits between the dual-bank (even/odd) icache in the frontend and the L2 interface.
- Arbitrates among the even demand miss, the odd demand miss and the branch-predictor prefetch. One L2 read is outstanding at a time.
- Selects the 128b icache sub-line from each 512b L2 line and drives the frontend stall while demand misses are pending.

Parameters:
- XLEN, 32, address width.
- CL_SIZE, 128, icache line width in bits.
- L2_CL_SIZE, 512, L2 line width in bits; L2_CL_SIZE/CL_SIZE = 4 sub-lines.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- miss_even_valid  in  1  even-bank demand miss.
- miss_even_addr  in  XLEN  even miss address.
- miss_odd_valid  in  1  odd-bank demand miss.
- miss_odd_addr  in  XLEN  odd miss address.
- prefetch_valid  in  1  prefetch request.
- prefetch_addr  in  XLEN  prefetch address.
- resteer  in  1  pipeline flush.
- l2_req_ready  in  1  L2 accepts the request this cycle.
- icache_l2_op  out  3  3'd0 NOP, 3'd1 READ.
- icache_l2_addr  out  XLEN  L2-line-aligned request address (bits [5:0]=0).
- l2_icache_op  in  3  3'd1 = read data return.
- l2_icache_addr  in  XLEN  returned line address.
- l2_icache_data  in  L2_CL_SIZE  returned line.
- l2_icache_state  in  3  coherence state of the returned line.
- fill_valid  out  1  write one icache line this cycle.
- fill_addr  out  XLEN  CL-aligned fill address (bits [3:0]=0).
- fill_data  out  CL_SIZE  fill line.
- fill_state  out  3  state passed through from L2.
- stall_out  out  1  demand miss pending.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset: all outputs 0, FSM=IDLE, all pending bits clear. Reset asserted mid-transaction drops it; any later L2 response does not match and is ignored.
- Pending slots: even, odd, pf. Each holds a valid bit and an address. A valid input sets the slot on the next edge; a set slot ignores new requests until serviced.
- A prefetch is dropped (not latched) if its L2 line (addr[XLEN-1:6]) matches a pending demand slot or the in-flight line.
- Priority when leaving IDLE: even > odd > pf.
- Merge: if even and odd are pending with equal addr[XLEN-1:6], a single READ services both.
- FSM IDLE:
  - Any slot pending → REQ. Latch the in-flight line address and the serviced-slot mask. Clear those slots.
- FSM REQ:
  - Drive icache_l2_op=READ and icache_l2_addr, registered and stable until l2_req_ready=1, then → WAIT.
  - resteer while in REQ and the request is not accepted → IDLE with op=NOP next cycle.
- FSM WAIT:
  - Leave when l2_icache_op==READ and l2_icache_addr[XLEN-1:6] equals the in-flight line; capture data and state, → FILL. Non-matching responses are ignored.
- FSM FILL:
  - One cycle per serviced demand/pf address (1 or 2 cycles), even before odd.
  - fill_data = data[CL_SIZE*addr[5:4] +: CL_SIZE]; fill_addr = {addr[XLEN-1:4],4'b0}.
  - After the last fill → IDLE.
- Latency, uncontended:
  - Miss at cycle 0 → latched at edge 1.
  - icache_l2_op=READ during cycle 2.
  - With ready in cycle 2, WAIT from cycle 3.
  - Response at cycle N → fill_valid at N+1.
- stall_out = OR of pending even/odd slots, or in-flight mask contains a demand. It deasserts in the cycle after the last demand fill.
- resteer:
  - Clears all pending slots next edge.
  - A request already accepted (WAIT/FILL) completes and still fills, but stall_out drops the cycle after resteer.
  - A miss input coinciding with resteer is discarded.
- Simultaneous events:
  - A new request in the same cycle its slot is cleared on leaving IDLE is latched.
  - In FILL, prefetch matching the in-flight line is dropped.

Decomposition:
- Shared frontend package holds:
  - L2 op encodings (NOP=0, READ=1, W, RWITM, FLUSH, UPDATE).
  - FSM state enum {IDLE, REQ, WAIT, FILL}.
  - Line-offset constants: L2 offset bits 6, CL offset bits 4.
- One natural sub-module: icache_miss_slot, a valid+address register with set/clear/flush and line-compare output. It is instantiated three times.

Test Plan:
- Even miss 0x0000_1040, ready=1, response addr 0x1040 after 5 cycles → icache_l2_addr=0x0000_1040 (op READ, cycle 2), fill_addr=0x1040, fill_data=data[127:0]... wait, offset [5:4]=0 → data[127:0]; stall_out falls the cycle after fill.
- Even 0x2000 + odd 0x2010 same cycle → single READ 0x2000; two fill cycles, 0x2000 (data[127:0]) then 0x2010 (data[255:128]).
- Even 0x3000 + odd 0x4010 → READ 0x3000 then READ 0x4000; odd fill selects data[255:128].
- Prefetch 0x5020 while idle, then a response addr 0x6000 injected → ignored; the 0x5000 response fills 0x5020 from data[383:256]; stall_out stays 0 throughout.
- Even miss, then resteer during REQ with ready=0 → op returns to NOP, FSM IDLE, no fill, stall_out=0.
- rst asserted during WAIT, then response arrives → no fill_valid; all outputs 0.
